// File: rtl/riscv_mult_seq_pkg.sv
// Shared types and operand-signedness helpers for the iterative multiply/MAC unit.
package riscv_mult_seq_pkg;

  typedef enum logic [2:0] {
    MUL_LO  = 3'd0,
    MUL_HSS = 3'd1,
    MUL_HSU = 3'd2,
    MUL_HUU = 3'd3,
    MUL_MAC = 3'd4,
    MUL_MSU = 3'd5
  } mult_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mult_state_t;

  // Encodings 6 and 7 are not defined operators; they execute as a plain low-half multiply.
  function automatic mult_op_t legal_op(input logic [2:0] op);
    return (op > 3'd5) ? MUL_LO : mult_op_t'(op);
  endfunction

  function automatic logic a_signed(input mult_op_t op);
    return op != MUL_HUU;
  endfunction

  function automatic logic b_signed(input mult_op_t op);
    return (op == MUL_LO) || (op == MUL_HSS) || (op == MUL_MAC) || (op == MUL_MSU);
  endfunction

endpackage

// File: rtl/riscv_mult_slice.sv
// Combinational signed (WIDTH+1) x (SLICE+1) multiply with optional negation.
// Kept as a separate block so the multiplier maps cleanly onto a DSP primitive.
module riscv_mult_slice #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic signed [WIDTH:0]         a,
  input  logic signed [SLICE:0]         b,
  input  logic                          neg,
  output logic signed [WIDTH+SLICE+1:0] prod
);

  localparam int PW = WIDTH + SLICE + 2;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] p;

  assign a_x  = {{(PW-WIDTH-1){a[WIDTH]}}, a};
  assign b_x  = {{(PW-SLICE-1){b[SLICE]}}, b};
  assign p    = a_x * b_x;
  assign prod = neg ? -p : p;

endmodule

// File: rtl/riscv_mult_seq.sv
// Iterative MUL/MULH/MAC/MSU: one SLICE of B per cycle, result valid N+1 cycles after accept.
// Result is held in DONE until ready_i; a new request can be taken in that same cycle; flush_i aborts.
module riscv_mult_seq
  import riscv_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N) + 1;
  localparam int AW = 2 * WIDTH + 2;
  localparam int PW = WIDTH + SLICE + 2;
  localparam int SW = $clog2(AW);

  mult_state_t             state;
  logic [CW-1:0]           cnt;
  mult_op_t                op_q;
  logic signed [WIDTH:0]   a_q;
  logic [WIDTH-1:0]        b_q;
  logic                    b_sgn_q;
  logic signed [AW-1:0]    acc;

  mult_op_t                op_in;
  logic                    accept;
  logic                    last;
  logic signed [SLICE:0]   b_slice;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_ext;
  logic [SW-1:0]           shamt;
  logic signed [AW-1:0]    acc_nxt;
  logic signed [AW-1:0]    acc_init;
  logic [WIDTH-1:0]        res_nxt;

  assign op_in   = legal_op(operator_i);
  assign ready_o = !flush_i && ((state == IDLE) || ((state == DONE) && ready_i));
  assign accept  = valid_i && ready_o;
  assign last    = (cnt == CW'(N - 1));

  // b_q shifts down one slice per step, so its low SLICE bits are always the current slice.
  assign b_slice  = {last & b_sgn_q & b_q[SLICE-1], b_q[SLICE-1:0]};
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign shamt    = SW'(cnt) * SW'(SLICE);
  assign acc_nxt  = acc + (prod_ext <<< shamt);
  assign acc_init = ((op_in == MUL_MAC) || (op_in == MUL_MSU)) ?
                    {{(AW-WIDTH){op_c_i[WIDTH-1]}}, op_c_i} : '0;
  assign res_nxt  = ((op_q == MUL_HSS) || (op_q == MUL_HSU) || (op_q == MUL_HUU)) ?
                    acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

  riscv_mult_slice #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) u_slice (
    .a   (a_q),
    .b   (b_slice),
    .neg (op_q == MUL_MSU),
    .prod(prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      op_q     <= MUL_LO;
      a_q      <= '0;
      b_q      <= '0;
      b_sgn_q  <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          b_q <= b_q >> SLICE;
          if (last) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= res_nxt;
          end
        end
        DONE: begin
          if (ready_i) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // Accept overrides the DONE->IDLE move so a queued request starts back-to-back.
      if (accept) begin
        state   <= BUSY;
        busy_o  <= 1'b1;
        cnt     <= '0;
        acc     <= acc_init;
        op_q    <= op_in;
        a_q     <= {a_signed(op_in) & op_a_i[WIDTH-1], op_a_i};
        b_q     <= op_b_i;
        b_sgn_q <= b_signed(op_in);
      end
    end
  end

endmodule

// File: doc/riscv_mult_seq.md
Name: riscv_mult_seq

Overview:
- Parametrised, iterative integer multiply/MAC unit for the EX stage. It succeeds the fixed 32-bit, 16x16-sliced MULH sequencer.
- Computes the full 2*WIDTH-bit product by consuming one SLICE-bit chunk of operand B per cycle against the full operand A.
- Covers all RV M-extension multiply variants plus MAC/MSU, with valid/ready handshakes on both sides, result hold under back-pressure, and flush.

Parameters:
- WIDTH, 32: operand/result width. Legal values are 32 and 64.
- SLICE, 16: bits of B consumed per cycle. WIDTH % SLICE must be 0.
- Derived, not overridable: N = WIDTH/SLICE (iteration count); CW = $clog2(N) + 1 (counter width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i & ready_o
- operator_i  in  3  mult_op_t
- op_a_i  in  WIDTH  multiplicand (rs1)
- op_b_i  in  WIDTH  multiplier (rs2)
- op_c_i  in  WIDTH  accumulator for MAC/MSU; ignored otherwise
- flush_i  in  1  abort any in-flight operation
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  result
- busy_o  out  1  high in BUSY or DONE (drives multicycle stall)

Behaviour:
- Reset (rst high at posedge): state=IDLE, counter=0, accumulator=0. Outputs: valid_o=0, busy_o=0, result_o=0, ready_o=1. Reset mid-operation discards the operation with no residual state.
- Operand extension to WIDTH+1 bits:
  - A is signed for MUL_HSS, MUL_HSU, MUL_LO, MAC, MSU.
  - B is signed for MUL_HSS, MUL_LO, MAC, MSU.
  - All others are zero-extended.
  - Low-half ops are sign-agnostic.
- FSM states IDLE, BUSY, DONE:
  - IDLE: ready_o=1. On accept, latch the op and operands, set counter=0, and initialise the accumulator to sext(op_c_i) for MAC/MSU, else 0. Next state BUSY.
  - BUSY: ready_o=0. Each cycle, accumulator += (±A_ext * Bslice[k]) << (k*SLICE). The product is negated for MSU. Bslice[k] is unsigned except slice N-1, which is sign-extended when B is signed. The counter increments. After step k=N-1, next state is DONE. Exactly N cycles in BUSY.
  - DONE: valid_o=1, and result_o is held stable until the handshake.
    - On ready_i: if valid_i is also high, accept the new request in the same cycle (ready_o = ready_i in DONE) and go to BUSY. Otherwise go to IDLE.
    - Without ready_i, stay in DONE with all outputs frozen.
- Latency: request accepted at edge t → valid_o high in the cycle after edge t+N. That is N+1 cycles from accept to result; throughput is one op per N+1 cycles.
- Result selection:
  - MUL_LO/MAC/MSU: accumulator[WIDTH-1:0]. MAC/MSU wrap modulo 2^WIDTH.
  - MUL_HSS/HSU/HUU: accumulator[2*WIDTH-1:WIDTH].
  - Accumulator width is 2*WIDTH+2 bits so that no intermediate overflow occurs.
  - In IDLE and BUSY, result_o=0.
- flush_i: takes priority over everything except rst. Next state is IDLE, valid_o drops next cycle, and no result is produced. flush_i in the same cycle as valid_i means the request is not accepted (ready_o is forced 0 while flush_i=1).
- Illegal operator_i (6, 7): treated as MUL_LO.
- Simultaneous valid_i in BUSY: ignored; the requester holds valid_i until ready_o.

Decomposition:
- Package riscv_mult_seq_pkg:
  - typedef enum logic [2:0] mult_op_t: MUL_LO=0, MUL_HSS=1, MUL_HSU=2, MUL_HUU=3, MUL_MAC=4, MUL_MSU=5.
  - typedef enum mult_state_t: IDLE, BUSY, DONE.
  - Helper functions a_signed(op) and b_signed(op).
- One sub-module, riscv_mult_slice: purely combinational (WIDTH+1) x (SLICE+1) signed multiply with a negate control. It isolates the DSP-inferrable multiplier.
- The top level holds the FSM, counter, operand registers, and accumulator.

Test Plan:
1. WIDTH=32, SLICE=16. MUL_HSS with a=0x80000000, b=0x80000000 → result 0x40000000. valid_o rises exactly 3 cycles after accept.
2. MUL_HUU with a=b=0xFFFFFFFF → 0xFFFFFFFE. MUL_HSU with a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MUL_LO with a=7, b=0xFFFFFFFD → 0xFFFFFFEB.
3. MAC with c=10, a=3, b=4 → 22. MSU with c=10, a=3, b=4 → 0xFFFFFFFE. MAC with c=0xFFFFFFFF, a=1, b=1 → 0 (wrap).
4. Back-pressure: hold ready_i=0 for 5 cycles in DONE → valid_o and result_o stable. Then ready_i=1 with a new valid_i → accepted that cycle, next result valid N+1 cycles later.
5. Pulse flush_i in the second BUSY cycle → IDLE next cycle, valid_o never asserted. Assert rst mid-BUSY → all outputs at reset values next cycle.
6. WIDTH=64, SLICE=8 (N=8): random 10k ops checked against a 128-bit reference model, including ±2^63, 0, and -1 corners; latency exactly 9 cycles.
